// File: rtl/dcache_miss_handler_pkg.sv
// Shared types for the data-cache miss handler: the word type and the
// responder FSM state encoding.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } dmh_state_t;

endpackage

// File: rtl/dcache_miss_handler_if.sv
// Bundle between the data store / RAM port and the miss handler.
// Handshake: dmissREN and ddirtyWEN are held with stable address/data until
// served (dwait low for one cycle) or accepted (full low at the edge); a RAM
// access holds its strobe and payload until the edge where ramwait is low.
interface dcache_miss_handler_if;
  import cpu_types_pkg::*;

  logic  dmissREN;
  word_t rdaddr;
  logic  ddirtyWEN;
  word_t ddirtyaddr;
  word_t ddirtydata;
  logic  halt;
  logic  dwait;
  word_t dload;
  logic  full;
  logic  flushed;
  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  logic  ramwait;

  modport master (
    output dmissREN, rdaddr, ddirtyWEN, ddirtyaddr, ddirtydata, halt,
    output ramload, ramwait,
    input  dwait, dload, full, flushed, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    input  dmissREN, rdaddr, ddirtyWEN, ddirtyaddr, ddirtydata, halt,
    input  ramload, ramwait,
    output dwait, dload, full, flushed, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/dcache_miss_handler_wb_buffer.sv
// Circular write-back buffer of dirty words with a youngest-match lookup that
// also sees the push being accepted this cycle.
module dirty_wb_buffer
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  word_t         i_push_addr,
  input  word_t         i_push_data,
  input  logic          i_pop,
  input  word_t         i_lookup_addr,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count,
  output word_t         o_head_addr,
  output word_t         o_head_data,
  output logic          o_match,
  output word_t         o_match_data
);

  word_t         r_addr [DEPTH];
  word_t         r_data [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_full;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && (r_count != '0);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) begin
        r_addr[r_wr_ptr] <= i_push_addr;
        r_data[r_wr_ptr] <= i_push_data;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end

  // Walk oldest to youngest so the last hit wins; the incoming push is youngest.
  always_comb begin
    logic [PW-1:0] idx;
    idx          = '0;
    o_match      = 1'b0;
    o_match_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_rd_ptr + PW'(i);
      if ((CW'(i) < r_count) && (r_addr[idx] == i_lookup_addr)) begin
        o_match      = 1'b1;
        o_match_data = r_data[idx];
      end
    end
    if (w_push && (i_push_addr == i_lookup_addr)) begin
      o_match      = 1'b1;
      o_match_data = i_push_data;
    end
  end

  assign o_full      = r_full;
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;
  assign o_head_addr = r_addr[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];

endmodule

// File: rtl/dcache_miss_handler.sv
// Memory-side responder: serves miss reads (forwarding from the write-back
// buffer when possible) and drains buffered dirty words to RAM in order.
module dcache_miss_handler
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  dcache_miss_handler_if.slave  bus,
  output dmh_state_t            o_dbg_state,
  output logic [CW-1:0]         o_dbg_count
);

  dmh_state_t    r_state;
  logic          r_dwait;
  word_t         r_dload;
  logic          r_flushed;
  logic          r_ramREN;
  logic          r_ramWEN;
  word_t         r_ramaddr;
  word_t         r_ramstore;

  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  word_t         w_head_addr;
  word_t         w_head_data;
  logic          w_match;
  word_t         w_match_data;
  logic          w_pop;

  assign w_pop = (r_state == WRITE) && !bus.ramwait;

  dirty_wb_buffer #(.DEPTH(DEPTH)) u_wb_buffer (
    .i_clk         (CLK),
    .i_rst         (RST),
    .i_push        (bus.ddirtyWEN),
    .i_push_addr   (bus.ddirtyaddr),
    .i_push_data   (bus.ddirtydata),
    .i_pop         (w_pop),
    .i_lookup_addr (bus.rdaddr),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_count       (w_count),
    .o_head_addr   (w_head_addr),
    .o_head_data   (w_head_data),
    .o_match       (w_match),
    .o_match_data  (w_match_data)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_dwait    <= 1'b1;
      r_dload    <= '0;
      r_flushed  <= 1'b0;
      r_ramREN   <= 1'b0;
      r_ramWEN   <= 1'b0;
      r_ramaddr  <= '0;
      r_ramstore <= '0;
    end else begin
      if (bus.halt && w_empty && (r_state == IDLE) && !bus.dmissREN) begin
        r_flushed <= 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (bus.dmissREN && w_match) begin
            r_dload <= w_match_data;
            r_dwait <= 1'b0;
            r_state <= RESP;
          end else if (bus.dmissREN) begin
            r_ramREN  <= 1'b1;
            r_ramaddr <= bus.rdaddr;
            r_state   <= READ;
          end else if (!w_empty) begin
            r_ramWEN   <= 1'b1;
            r_ramaddr  <= w_head_addr;
            r_ramstore <= w_head_data;
            r_state    <= WRITE;
          end
        end
        READ: begin
          if (!bus.ramwait) begin
            r_dload  <= bus.ramload;
            r_ramREN <= 1'b0;
            r_dwait  <= 1'b0;
            r_state  <= RESP;
          end
        end
        // Writes always run to completion; a pending miss is picked up in IDLE.
        WRITE: begin
          if (!bus.ramwait) begin
            r_ramWEN <= 1'b0;
            r_state  <= IDLE;
          end
        end
        RESP: begin
          r_dwait <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.dwait    = r_dwait;
  assign bus.dload    = r_dload;
  assign bus.full     = w_full;
  assign bus.flushed  = r_flushed;
  assign bus.ramREN   = r_ramREN;
  assign bus.ramWEN   = r_ramWEN;
  assign bus.ramaddr  = r_ramaddr;
  assign bus.ramstore = r_ramstore;

  assign o_dbg_state = r_state;
  assign o_dbg_count = w_count;

endmodule

// File: tb/tb_dcache_miss_handler.sv
// Bench for dcache_miss_handler: a RAM responder plus a value-level model
// (shadow memory of every accepted dirty word, FIFO of pending writes).
module tb_dcache_miss_handler;
  import cpu_types_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  dcache_miss_handler_if bus();
  dmh_state_t    dbg_state;
  logic [CW-1:0] dbg_count;

  dcache_miss_handler #(.DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_count (dbg_count)
  );

  // ---------------- model state ----------------
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] shadow[logic [31:0]];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] exp_q[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          chk_en = 0;
  logic [31:0] cur_miss_addr = '0;
  bit          miss_pending = 0;
  bit          resp_seen = 0;
  int          resp_cyc = 0;
  int          issue_cyc = 0;
  logic [31:0] last_dload = '0;
  bit          push_acc = 0;
  int          wr_done = 0;
  int          wr_at_read = 0;
  int          n_read_starts = 0;
  int          fixed_wait = -1;
  int          wait_pct = 0;
  int          acc_cnt = 0;
  bit          prev_ren = 0;
  int          mon_sz;
  ent_t        mon_e;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  function automatic void check_eq(input string nm, input logic [31:0] act,
                                   input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- RAM responder + scoreboard ----------------
  always @(negedge CLK) begin
    if (bus.ramREN || bus.ramWEN) begin
      if (fixed_wait >= 0) bus.ramwait = (acc_cnt < fixed_wait);
      else                 bus.ramwait = ($urandom_range(0, 99) < wait_pct);
    end else begin
      bus.ramwait = 1'($urandom_range(0, 1));
    end
    bus.ramload = (bus.ramREN === 1'b1) ? mem_rd(bus.ramaddr) : $urandom;
    push_acc = 0;

    if (RST) begin
      mq.delete();
      exp_q.delete();
      miss_pending = 0;
      shadow = mem;
      acc_cnt = 0;
      prev_ren = 0;
    end else if (chk_en) begin
      mon_sz = mq.size();
      check_eq("full", 32'(bus.full), 32'(mon_sz == DEPTH));
      if (bus.ramREN || bus.ramWEN)
        check_eq("one_strobe", 32'(bus.ramREN & bus.ramWEN), 32'd0);
      if (bus.ramREN) begin
        check_eq("read_pending", 32'(miss_pending), 32'd1);
        check_eq("read_addr", bus.ramaddr, cur_miss_addr);
        if (!prev_ren) begin
          wr_at_read = wr_done;
          n_read_starts++;
        end
      end
      if (!bus.dwait) begin
        check_eq("resp_expected", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
          check_eq("dload", bus.dload, exp_q.pop_front());
          resp_seen = 1;
          resp_cyc = cyc;
          last_dload = bus.dload;
          miss_pending = 0;
        end
      end
      if (bus.ramWEN && !bus.ramwait) begin
        check_eq("wr_queued", 32'(mq.size() > 0), 32'd1);
        if (mq.size() > 0) begin
          mon_e = mq.pop_front();
          check_eq("wr_addr", bus.ramaddr, mon_e.a);
          check_eq("wr_data", bus.ramstore, mon_e.d);
          mem[mon_e.a] = mon_e.d;
          wr_done++;
        end
      end
      if (bus.ddirtyWEN && (mon_sz < DEPTH)) begin
        mq.push_back('{a: bus.ddirtyaddr, d: bus.ddirtydata});
        shadow[bus.ddirtyaddr] = bus.ddirtydata;
        push_acc = 1;
      end
      if ((bus.ramREN || bus.ramWEN) && bus.ramwait) acc_cnt++;
      else acc_cnt = 0;
      prev_ren = bus.ramREN;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_pulse();
    tick();
    RST = 1'b1;
    bus.dmissREN = 1'b0;
    bus.ddirtyWEN = 1'b0;
    bus.halt = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  task automatic do_push(input logic [31:0] a, input logic [31:0] d);
    bus.ddirtyWEN = 1'b1;
    bus.ddirtyaddr = a;
    bus.ddirtydata = d;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (push_acc) break;
    end
    check_eq("push_accepted", 32'(push_acc), 32'd1);
    bus.ddirtyWEN = 1'b0;
  endtask

  task automatic issue_miss(input logic [31:0] a, input logic [31:0] e);
    bus.dmissREN = 1'b1;
    bus.rdaddr = a;
    exp_q.push_back(e);
    cur_miss_addr = a;
    miss_pending = 1;
    resp_seen = 0;
    issue_cyc = cyc;
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 300; i++) begin
      tick();
      if (resp_seen) break;
    end
    check_eq("resp_in_time", 32'(resp_seen), 32'd1);
    bus.dmissREN = 1'b0;
    if (!resp_seen) begin
      exp_q.delete();
      miss_pending = 0;
    end
  endtask

  task automatic do_miss(input logic [31:0] a);
    issue_miss(a, shadow_rd(a));
    wait_resp();
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && mq.size() != 0; i++) tick();
    check_eq("drained", 32'(mq.size()), 32'd0);
    tick();
    tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : main
    int wd;
    int rs;
    logic [31:0] a;
    bus.dmissREN = 1'b0;
    bus.rdaddr = '0;
    bus.ddirtyWEN = 1'b0;
    bus.ddirtyaddr = '0;
    bus.ddirtydata = '0;
    bus.halt = 1'b0;
    bus.ramwait = 1'b1;
    bus.ramload = '0;
    repeat (3) tick();
    RST = 1'b0;

    check_eq("rst_dwait", 32'(bus.dwait), 32'd1);
    check_eq("rst_dload", bus.dload, 32'd0);
    check_eq("rst_full", 32'(bus.full), 32'd0);
    check_eq("rst_flushed", 32'(bus.flushed), 32'd0);
    check_eq("rst_ramREN", 32'(bus.ramREN), 32'd0);
    check_eq("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    check_eq("rst_ramaddr", bus.ramaddr, 32'd0);
    check_eq("rst_ramstore", bus.ramstore, 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
    chk_en = 1;

    // RAM miss with two wait cycles
    fixed_wait = 2;
    mem[32'h100] = 32'hDEADBEEF;
    shadow[32'h100] = 32'hDEADBEEF;
    do_miss(32'h100);
    check_eq("miss_deadbeef", last_dload, 32'hDEADBEEF);
    check_eq("miss_wait2_latency", 32'(resp_cyc - issue_cyc), 32'd4);
    check_eq("ren_dropped", 32'(bus.ramREN), 32'd0);
    check_eq("dwait_back_high", 32'(bus.dwait), 32'd1);

    // RAM miss, no wait cycles
    fixed_wait = 0;
    do_miss(32'h104);
    check_eq("miss_latency", 32'(resp_cyc - issue_cyc), 32'd2);
    check_eq("miss_104", last_dload, init_val(32'h104));

    // Forwarding: second push to same address arrives with the miss
    drain();
    rs = n_read_starts;
    do_push(32'h40, 32'h1111_1111);
    bus.ddirtyWEN = 1'b1;
    bus.ddirtyaddr = 32'h40;
    bus.ddirtydata = 32'h2222_2222;
    issue_miss(32'h40, 32'h2222_2222);
    tick();
    bus.ddirtyWEN = 1'b0;
    if (!resp_seen) wait_resp();
    else bus.dmissREN = 1'b0;
    check_eq("fwd_data", last_dload, 32'h2222_2222);
    check_eq("fwd_latency", 32'(resp_cyc - issue_cyc), 32'd1);
    check_eq("fwd_no_read", 32'(n_read_starts - rs), 32'd0);

    // Forwarding from buffered entries while a write is stalled
    drain();
    fixed_wait = 100000;
    do_push(32'h44, 32'hAAAA_0001);
    do_push(32'h44, 32'hAAAA_0002);
    tick();
    issue_miss(32'h44, shadow_rd(32'h44));
    tick();
    fixed_wait = 0;
    wait_resp();
    check_eq("fwd_buffered", last_dload, 32'hAAAA_0002);

    // Fill / overflow with RAM stalled
    drain();
    fixed_wait = 100000;
    for (int i = 0; i < 5; i++) begin
      bus.ddirtyWEN = 1'b1;
      bus.ddirtyaddr = 32'h600 + 32'(4 * i);
      bus.ddirtydata = 32'hF000_0000 + 32'(i);
      tick();
    end
    bus.ddirtyWEN = 1'b0;
    check_eq("fill_full", 32'(bus.full), 32'd1);
    check_eq("fill_model_size", 32'(mq.size()), 32'd4);
    wd = wr_done;
    fixed_wait = 0;
    for (int i = 0; i < 100 && (wr_done - wd) < 4; i++) tick();
    repeat (4) tick();
    check_eq("fill_writes", 32'(wr_done - wd), 32'd4);
    check_eq("fill_5th_dropped", 32'(mem.exists(32'h610)), 32'd0);
    check_eq("fill_not_full", 32'(bus.full), 32'd0);

    // Miss arriving during a stalled write
    drain();
    fixed_wait = 100000;
    do_push(32'h80, 32'h8080_0001);
    for (int i = 0; i < 50 && !bus.ramWEN; i++) tick();
    check_eq("mdw_wen", 32'(bus.ramWEN), 32'd1);
    issue_miss(32'h200, shadow_rd(32'h200));
    repeat (3) tick();
    check_eq("mdw_no_ren", 32'(bus.ramREN), 32'd0);
    check_eq("mdw_wr_addr", bus.ramaddr, 32'h80);
    wd = wr_done;
    fixed_wait = 0;
    wait_resp();
    check_eq("mdw_write_first", 32'(wr_at_read), 32'(wd + 1));

    // Halt with two buffered entries
    drain();
    fixed_wait = 100000;
    do_push(32'h300, 32'h3000_0001);
    do_push(32'h304, 32'h3000_0002);
    bus.halt = 1'b1;
    tick();
    tick();
    check_eq("halt_not_yet", 32'(bus.flushed), 32'd0);
    wd = wr_done;
    fixed_wait = 0;
    for (int i = 0; i < 50 && !bus.flushed; i++) tick();
    check_eq("halt_flushed", 32'(bus.flushed), 32'd1);
    check_eq("halt_writes", 32'(wr_done - wd), 32'd2);
    bus.halt = 1'b0;
    repeat (3) tick();
    check_eq("flushed_sticky", 32'(bus.flushed), 32'd1);
    reset_pulse();
    check_eq("flushed_cleared", 32'(bus.flushed), 32'd0);

    // Reset in the middle of a READ
    fixed_wait = 100000;
    issue_miss(32'h500, shadow_rd(32'h500));
    for (int i = 0; i < 20 && !bus.ramREN; i++) tick();
    check_eq("mid_read_ren", 32'(bus.ramREN), 32'd1);
    reset_pulse();
    check_eq("rr_ramREN", 32'(bus.ramREN), 32'd0);
    check_eq("rr_dwait", 32'(bus.dwait), 32'd1);
    check_eq("rr_full", 32'(bus.full), 32'd0);
    check_eq("rr_state", 32'(dbg_state), 32'(IDLE));
    check_eq("rr_count", 32'(dbg_count), 32'd0);
    fixed_wait = -1;
    wait_pct = 40;

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      a = 32'h1000 + 32'(4 * $urandom_range(0, 15));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: do_push(a, $urandom);
        5, 6, 7:       do_miss(a);
        default:       repeat ($urandom_range(1, 3)) tick();
      endcase
      if (n % 50 == 49) wait_pct = $urandom_range(0, 70);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
